// File: rtl/pbvi_pkg.sv
// Shared types for the POMDP decision path.
// Q8.8 belief/alpha elements, action tags and decision FSM states.
package pbvi_pkg;

  localparam int W_DEF = 16;
  localparam int FRAC  = 8;

  typedef logic [1:0] action_t;

  typedef struct packed {
    logic                  valid;
    action_t               action;
    logic [1:0][W_DEF-1:0] alpha;
  } alpha_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } dec_state_t;

endpackage

// File: rtl/pbvi_alpha_dot.sv
// Two-element unsigned dot product, full precision.
// Shared with the alpha-backup stage.
module pbvi_alpha_dot
  import pbvi_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a [1:0],
  input  logic [W-1:0] b [1:0],
  output logic [2*W:0] dot
);

  logic [2*W-1:0] p0;
  logic [2*W-1:0] p1;

  assign p0  = {{W{1'b0}}, a[0]} * {{W{1'b0}}, b[0]};
  assign p1  = {{W{1'b0}}, a[1]} * {{W{1'b0}}, b[1]};
  assign dot = {1'b0, p0} + {1'b0, p1};

endmodule

// File: rtl/pbvi_decision.sv
// PBVI action selection: scans the alpha table, picks the max dot product.
// Optional best_value output under PBVI_DECISION_VALUE_OUT_EN.
module pbvi_decision
  import pbvi_pkg::*;
#(
  parameter  int NUM_ALPHA = 8,
  parameter  int W         = W_DEF,
  localparam int AW        = $clog2(NUM_ALPHA)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  belief_in [1:0],
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_alpha [1:0],
  input  logic [1:0]    wr_action,
  input  logic          wr_valid,
  output logic          busy,
  output logic [1:0]    action_out,
  output logic [AW-1:0] best_idx,
  output logic          action_valid,
  output logic          no_valid
`ifdef PBVI_DECISION_VALUE_OUT_EN
  ,
  output logic [2*W:0]  best_value
`endif
);

  dec_state_t state;
  dec_state_t state_nxt;

  logic [1:0][W-1:0] tbl_alpha [NUM_ALPHA];
  logic [1:0]        tbl_act   [NUM_ALPHA];
  logic [NUM_ALPHA-1:0] tbl_vld;

  logic [W-1:0]  belief_r [1:0];
  logic [W-1:0]  alpha_cur [1:0];
  logic [AW-1:0] idx;
  logic [AW-1:0] best_idx_r;
  logic [1:0]    best_act;
  logic [2*W:0]  best_val;
  logic          found;

  logic [2*W:0]  val;
  logic          last;
  logic          take;
  logic          nxt_found;
  logic [1:0]    nxt_act;
  logic [AW-1:0] nxt_idx;
  logic [2*W:0]  nxt_val;
  logic          tbl_wr;

  assign alpha_cur[0] = tbl_alpha[idx][0];
  assign alpha_cur[1] = tbl_alpha[idx][1];

  pbvi_alpha_dot #(
    .W(W)
  ) u_dot (
    .a  (alpha_cur),
    .b  (belief_r),
    .dot(val)
  );

  assign last = (idx == AW'(NUM_ALPHA - 1));

  // Strict compare: ties keep the earlier (lower) index.
  assign take      = tbl_vld[idx] && (!found || (val > best_val));
  assign nxt_found = found | take;
  assign nxt_act   = take ? tbl_act[idx] : best_act;
  assign nxt_idx   = take ? idx : best_idx_r;
  assign nxt_val   = take ? val : best_val;

  assign busy         = (state != IDLE);
  assign action_valid = (state == DONE);

  // Table is frozen outside IDLE so a scan sees a stable snapshot.
  assign tbl_wr = wr_en && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_vld <= '0;
    end else if (tbl_wr) begin
      tbl_vld[wr_addr] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_wr) begin
      tbl_alpha[wr_addr] <= {wr_alpha[1], wr_alpha[0]};
      tbl_act[wr_addr]   <= wr_action;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      belief_r[0] <= '0;
      belief_r[1] <= '0;
      idx         <= '0;
      best_idx_r  <= '0;
      best_act    <= '0;
      best_val    <= '0;
      found       <= 1'b0;
      action_out  <= '0;
      best_idx    <= '0;
      no_valid    <= 1'b0;
`ifdef PBVI_DECISION_VALUE_OUT_EN
      best_value  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            belief_r[0] <= belief_in[0];
            belief_r[1] <= belief_in[1];
            idx         <= '0;
            best_idx_r  <= '0;
            best_act    <= '0;
            best_val    <= '0;
            found       <= 1'b0;
          end
        end
        SCAN: begin
          found      <= nxt_found;
          best_act   <= nxt_act;
          best_idx_r <= nxt_idx;
          best_val   <= nxt_val;
          idx        <= idx + AW'(1);
          // Result lands on the edge into DONE, aligned with the pulse.
          if (last) begin
            action_out <= nxt_found ? nxt_act : 2'd0;
            best_idx   <= nxt_found ? nxt_idx : '0;
            no_valid   <= !nxt_found;
`ifdef PBVI_DECISION_VALUE_OUT_EN
            best_value <= nxt_found ? nxt_val : '0;
`endif
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pbvi_decision.sv
// Scoreboard bench for pbvi_decision: directed cases plus random traffic.
// Expected results come from an argmax model of the alpha table.
module tb_pbvi_decision;

  localparam int NA = 8;
  localparam int W  = 16;
  localparam int AW = 3;
  localparam int LAT = NA;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  belief_in [1:0];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_alpha [1:0];
  logic [1:0]    wr_action;
  logic          wr_valid;
  logic          busy;
  logic [1:0]    action_out;
  logic [AW-1:0] best_idx;
  logic          action_valid;
  logic          no_valid;
`ifdef PBVI_DECISION_VALUE_OUT_EN
  logic [2*W:0]  best_value;
`endif

  pbvi_decision #(
    .NUM_ALPHA(NA),
    .W(W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .belief_in(belief_in),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_alpha(wr_alpha),
    .wr_action(wr_action),
    .wr_valid(wr_valid),
    .busy(busy),
    .action_out(action_out),
    .best_idx(best_idx),
    .action_valid(action_valid),
    .no_valid(no_valid)
`ifdef PBVI_DECISION_VALUE_OUT_EN
    ,
    .best_value(best_value)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     act;
    int     idx;
    bit     nov;
    longint val;
    int     due;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  bit     m_vld [NA];
  longint m_a0  [NA];
  longint m_a1  [NA];
  int     m_act [NA];
  int     busy_until = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected decision: highest dot product among valid entries,
  // lowest index wins on equal value.
  function automatic exp_t predict(input longint b0, input longint b1, input int e);
    exp_t r;
    longint best = -1;
    int bi = 0;
    for (int k = 0; k < NA; k++) begin
      if (m_vld[k]) begin
        longint v = m_a0[k] * b0 + m_a1[k] * b1;
        if (v > best) begin
          best = v;
          bi = k;
        end
      end
    end
    r.nov = (best < 0);
    r.act = r.nov ? 0 : m_act[bi];
    r.idx = r.nov ? 0 : bi;
    r.val = r.nov ? 0 : best;
    r.due = e + LAT;
    return r;
  endfunction

  task automatic drive(input bit s, input int b0, input int b1,
                       input bit w, input int addr, input int a0,
                       input int a1, input int act, input bit v);
    int e;
    bit idle;
    start        = s;
    belief_in[0] = W'(b0);
    belief_in[1] = W'(b1);
    wr_en        = w;
    wr_addr      = AW'(addr);
    wr_alpha[0]  = W'(a0);
    wr_alpha[1]  = W'(a1);
    wr_action    = 2'(act);
    wr_valid     = v;
    @(posedge clk);
    #1;
    e = cyc;
    idle = (e > busy_until);
    if (w && idle) begin
      m_vld[addr] = v;
      m_a0[addr]  = longint'(a0 & 16'hFFFF);
      m_a1[addr]  = longint'(a1 & 16'hFFFF);
      m_act[addr] = act & 3;
    end
    if (s && idle) begin
      q.push_back(predict(longint'(b0 & 16'hFFFF),
                          longint'(b1 & 16'hFFFF), e));
      busy_until = e + LAT + 1;
    end
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic wr(input int addr, input int a0, input int a1,
                    input int act, input bit v);
    drive(1'b0, 0, 0, 1'b1, addr, a0, a1, act, v);
  endtask

  task automatic go(input int b0, input int b1);
    drive(1'b1, b0, b1, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t ex;
    if (rst_n) begin
      if (q.size() > 0 && cyc > q[0].due) begin
        chk("timeout", cyc, q[0].due);
        void'(q.pop_front());
      end
      if (action_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          ex = q.pop_front();
          chk("latency", cyc, ex.due);
          chk("action", action_out, ex.act);
          chk("best_idx", best_idx, ex.idx);
          chk("no_valid", no_valid, ex.nov);
          chk("busy_in_done", busy, 1);
`ifdef PBVI_DECISION_VALUE_OUT_EN
          chk("best_value", best_value, ex.val);
`endif
        end
      end
    end
  end

  task automatic model_reset();
    q.delete();
    busy_until = 0;
    for (int k = 0; k < NA; k++) m_vld[k] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_action"}, action_out, 0);
    chk({tag, "_idx"}, best_idx, 0);
    chk({tag, "_valid"}, action_valid, 0);
    chk({tag, "_novalid"}, no_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    wr_en = 1'b0;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_action = '0;
    belief_in[0] = '0;
    belief_in[1] = '0;
    wr_alpha[0] = '0;
    wr_alpha[1] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // empty table
    go(16'h0080, 16'h0080);
    idle_n(11);

    // basic selection
    wr(0, 16'h0200, 16'h0000, 1, 1'b1);
    wr(1, 16'h0000, 16'h0300, 2, 1'b1);
    go(16'h0080, 16'h0080);
    idle_n(11);

    // tie between 3 and 5
    wr(0, 0, 0, 0, 1'b0);
    wr(1, 0, 0, 0, 1'b0);
    wr(3, 16'h0100, 16'h0100, 3, 1'b1);
    wr(5, 16'h0100, 16'h0100, 1, 1'b1);
    go(16'h0100, 16'h0000);
    idle_n(11);

    // start and write while busy are dropped
    go(16'h0100, 16'h0000);
    idle_n(2);
    drive(1'b1, 16'h0100, 16'h0100, 1'b1, 7,
          16'hFFFF, 16'hFFFF, 2, 1'b1);
    idle_n(12);
    go(16'h0100, 16'h0000);
    idle_n(11);

    // write and start in the same idle cycle
    drive(1'b1, 16'h0100, 16'h0100, 1'b1, 6,
          16'h0400, 16'h0400, 2, 1'b1);
    idle_n(11);

    // reset in the middle of a scan
    go(16'h0100, 16'h0100);
    idle_n(3);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_idle_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_n(12);
    go(16'h0100, 16'h0100);
    idle_n(11);

    // full-scale values
    wr(0, 16'hFFFF, 16'hFFFF, 3, 1'b1);
    go(16'hFFFF, 16'hFFFF);
    idle_n(11);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 4) begin
        wr($urandom_range(0, NA - 1), $urandom_range(0, 16'hFFFF),
           $urandom_range(0, 16'hFFFF), $urandom_range(0, 3),
           ($urandom_range(0, 3) != 0));
      end else if (r < 7) begin
        go($urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF));
      end else if (r == 7) begin
        drive(1'b1, $urandom_range(0, 16'hFFFF),
              $urandom_range(0, 16'hFFFF), 1'b1,
              $urandom_range(0, NA - 1), $urandom_range(0, 16'hFF),
              $urandom_range(0, 16'hFF), $urandom_range(0, 3), 1'b1);
      end else begin
        idle_n(1);
      end
    end

    idle_n(15);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pbvi_decision.md
Name: pbvi_decision

Overview:
- Downstream stage of the POMDP belief-update block. Consumes the renewed 2-state belief and its one-cycle `en_decision` strobe.
- Scans a locally stored table of PBVI alpha vectors, one per cycle, and computes dot(alpha_k, belief) for each.
- Selects the maximising vector and emits its associated action (2 bits) with a valid pulse. The action feeds back as the next belief-update action.

Parameters:
- NUM_ALPHA, 8, number of alpha-vector table entries (power of 2, ≥2)
- W, 16, belief/alpha element width, unsigned fixed point Q8.8
- AW, $clog2(NUM_ALPHA), table address width (derived, localparam)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  connect to en_decision; samples belief_in
- belief_in  in  2×W (unpacked [1:0])  renewed belief, Q8.8
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table entry index
- wr_alpha  in  2×W (unpacked [1:0])  alpha vector values, Q8.8
- wr_action  in  2  action tagged to entry
- wr_valid  in  1  entry valid bit written with the entry (0 = invalidate)
- busy  out  1  high in SCAN and DONE
- action_out  out  2  selected action, held until next DONE
- best_idx  out  AW  index of selected entry
- action_valid  out  1  one-cycle pulse in DONE
- no_valid  out  1  with action_valid: no valid entry found

Behaviour:
- Reset: state IDLE; busy=0, action_out=0, best_idx=0, action_valid=0, no_valid=0; all entry valid bits cleared; latched belief, accumulator, and index counter=0.
- FSM:
  - IDLE: start=1 → latch belief_in, idx=0, best_val=0, found=0 → SCAN.
  - SCAN: each cycle evaluate entry idx. val = a0*b0 + a1*b1, computed as unsigned 2W-bit products and a 2W+1-bit sum; no truncation in comparison. If entry valid and (found=0 or val > best_val), update best_val, best_idx_r, best_act, and set found=1. Strictly greater, so ties keep the lowest index. At idx=NUM_ALPHA-1 → DONE; otherwise idx+1.
  - DONE: action_valid=1. If found: action_out=best_act, best_idx=best_idx_r, no_valid=0. Else: action_out=0, best_idx=0, no_valid=1. → IDLE.
- Latency: start sampled at edge N → action_valid high during cycle N+NUM_ALPHA+1.
- start while busy: ignored; no restart, no queueing.
- Table writes: accepted only in IDLE, taking effect next cycle. wr_en in SCAN/DONE is dropped, so the table is stable during a scan. A write and start in the same IDLE cycle: the write takes effect and the scan sees the new entry.
- Reset mid-scan: immediate return to reset values; no action_valid pulse.
- Belief is not renormalised here; any value is accepted.

Optional Feature:
- PBVI_DECISION_VALUE_OUT_EN
  - Defined: adds output port best_value [2W:0], the full-precision winning dot product. Updated in DONE, 0 on reset and when no_valid.
  - Undefined: port absent; best_val remains internal.

Decomposition:
- Package pbvi_pkg:
  - W default, Q8.8 FRAC=8 constant
  - typedef action_t (logic [1:0])
  - typedef alpha_entry_t struct {valid, action, alpha[1:0]}
  - enum dec_state_t {IDLE, SCAN, DONE}
- Sub-module pbvi_alpha_dot: purely combinational 2-element unsigned dot product, W inputs, 2W+1 output. Reusable by the alpha-backup stage.

Test Plan:
- Basic selection:
  - Stimulus: entries 0=(0x0200,0x0000,act1), 1=(0x0000,0x0300,act2), rest invalid; start with belief (0x0080,0x0080).
  - Response: vals 0x10000 and 0x18000 → action_out=2, best_idx=1, action_valid exactly 9 cycles after start (NUM_ALPHA=8).
- Tie:
  - Stimulus: entries 3 and 5 both (0x0100,0x0100) with act3/act1; belief (0x0100,0x0000).
  - Response: best_idx=3, action_out=3.
- Empty table:
  - Stimulus: start after reset.
  - Response: action_valid with no_valid=1, action_out=0, best_idx=0.
- Busy behaviour:
  - Stimulus: second start 3 cycles into scan, plus wr_en to entry 7 (0xFFFF,0xFFFF) during SCAN.
  - Response: single action_valid; entry 7 not written (a later scan shows the old result).
- Reset mid-scan:
  - Stimulus: assert rst_n=0 at cycle 4 of SCAN.
  - Response: busy=0, outputs 0, no action_valid pulse, table invalidated.
- Max-value width:
  - Stimulus: entry 0=(0xFFFF,0xFFFF), belief (0xFFFF,0xFFFF).
  - Response: selected with value 0x1FFFC0002; with PBVI_DECISION_VALUE_OUT_EN defined, best_value=0x1FFFC0002.
